// File: rtl/rf_read_arbiter_if.sv
// rtl/rf_read_arbiter_if.sv - request, read-mux and response signals of the register-file read arbiter
// The master side is the requesters, the mux and the consumer. The slave side is the arbiter.
interface rf_read_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int DATAW = 64
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0][4:0] req_reg;
    logic [NREQ-1:0]      req_ready;
    logic [4:0]           read_reg;
    logic [DATAW-1:0]     read_data;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [4:0]           rsp_reg;
    logic [DATAW-1:0]     rsp_data;

    modport master (
        output req_valid, req_reg, read_data, rsp_ready,
        input  req_ready, read_reg, rsp_valid, rsp_id, rsp_reg, rsp_data
    );

    modport slave (
        input  req_valid, req_reg, read_data, rsp_ready,
        output req_ready, read_reg, rsp_valid, rsp_id, rsp_reg, rsp_data
    );
endinterface

// File: rtl/rf_read_arbiter.sv
// rtl/rf_read_arbiter.sv - arbitrates NREQ requesters onto one register-file read mux, two-stage pipeline
// Define RF_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest index wins.
module rf_read_arbiter #(
    parameter int NREQ  = 4,
    parameter int DATAW = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    rf_read_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);

    logic             a_valid;
    logic [IDW-1:0]   a_id;
    logic [4:0]       read_reg;
    logic             rsp_valid;
    logic [IDW-1:0]   rsp_id;
    logic [4:0]       rsp_reg;
    logic [DATAW-1:0] rsp_data;
    logic [IDW-1:0]   ptr;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_id;
    logic             grant_any;
    logic             a_load;
    logic             b_load;
    logic             handshake;

    assign b_load    = a_valid & (~rsp_valid | bus.rsp_ready);
    assign a_load    = ~a_valid | b_load;
    assign handshake = grant_any & a_load & rst_n;

    // The grant is formed from req_valid and ptr only, so it cannot loop back through req_ready.
    always_comb begin
        logic [IDW-1:0] idx;
        idx       = '0;
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!grant_any && bus.req_valid[idx]) begin
                grant_any   = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = idx;
            end
        end
    end

`ifdef RF_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (handshake) begin
            ptr <= (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
        end
    end
`else
    assign ptr = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_reg  <= 5'd31;
            a_valid   <= 1'b0;
            a_id      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_reg   <= '0;
            rsp_data  <= '0;
        end else begin
            // read_reg holds while stage A is stalled, keeping read_data valid for capture.
            if (a_load) begin
                if (handshake) begin
                    read_reg <= bus.req_reg[grant_id];
                    a_id     <= grant_id;
                    a_valid  <= 1'b1;
                end else begin
                    a_valid  <= 1'b0;
                end
            end
            if (b_load) begin
                rsp_data  <= bus.read_data;
                rsp_reg   <= read_reg;
                rsp_id    <= a_id;
                rsp_valid <= 1'b1;
            end else if (rsp_valid && bus.rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    assign bus.req_ready = grant & {NREQ{a_load & rst_n}};
    assign bus.read_reg  = read_reg;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_id    = rsp_id;
    assign bus.rsp_reg   = rsp_reg;
    assign bus.rsp_data  = rsp_data;
endmodule

// File: tb/tb_rf_read_arbiter.sv
// tb/tb_rf_read_arbiter.sv - self-checking bench for rf_read_arbiter against an in-flight queue model
// The expected arbitration order follows RF_ARB_ROUND_ROBIN_EN, so the bench matches either build.
module tb_rf_read_arbiter;
    localparam int NREQ  = 4;
    localparam int DATAW = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rf_read_arbiter_if #(.NREQ(NREQ), .DATAW(DATAW)) bus();

    logic [63:0] rf [32];
    assign bus.read_data = rf[bus.read_reg];

    rf_read_arbiter #(.NREQ(NREQ), .DATAW(DATAW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          id;
        logic [4:0]  r;
        logic [63:0] d;
        int          stamp;
    } item_t;

    item_t      q[$];
    int         obs_g[$];
    int         obs_r[$];
    int         ptr_m;
    int         now;
    int         last_hs;
    logic [4:0] last_reg;
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        q.delete();
        ptr_m    = 0;
        last_reg = 5'd31;
        last_hs  = -1;
    endtask

    task automatic set_req(input int i, input bit v, input logic [4:0] r);
        bus.req_valid[i] = v;
        bus.req_reg[i]   = r;
    endtask

    // Entered at a falling edge with inputs already applied; leaves at the next falling edge.
    task automatic step();
        int              eg;
        bit              acc;
        bit              exp_rv;
        logic [NREQ-1:0] exp_ready;
        #1;
        eg = -1;
        for (int k = 0; k < NREQ; k++) begin
            int j;
`ifdef RF_ARB_ROUND_ROBIN_EN
            j = (ptr_m + k) % NREQ;
`else
            j = k;
`endif
            if (eg < 0 && bus.req_valid[j]) eg = j;
        end
        // Two entries fit in flight; a full pipe only advances when the consumer accepts.
        acc = (q.size() < 2) || bus.rsp_ready;
        exp_ready = '0;
        if (eg >= 0 && acc) exp_ready[eg] = 1'b1;
        chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        chk("read_reg", 64'(bus.read_reg), 64'(last_reg));
        exp_rv = (q.size() > 0) && (q[0].stamp < now);
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
        if (exp_rv) begin
            chk("rsp_id", 64'(bus.rsp_id), 64'(q[0].id));
            chk("rsp_reg", 64'(bus.rsp_reg), 64'(q[0].r));
            chk("rsp_data", bus.rsp_data, q[0].d);
        end
        for (int i = 0; i < NREQ; i++)
            if (bus.req_valid[i] && bus.req_ready[i]) obs_g.push_back(i);
        if (bus.rsp_valid && bus.rsp_ready) obs_r.push_back(int'(bus.rsp_id));
        @(posedge clk);
        if (exp_rv && bus.rsp_ready) void'(q.pop_front());
        last_hs = -1;
        if (eg >= 0 && acc) begin
            item_t it;
            it.id    = eg;
            it.r     = bus.req_reg[eg];
            it.d     = rf[bus.req_reg[eg]];
            it.stamp = now + 1;
            q.push_back(it);
            last_reg = bus.req_reg[eg];
            last_hs  = eg;
            ptr_m    = (eg + 1) % NREQ;
        end
        now++;
        @(negedge clk);
    endtask

    task automatic rand_req();
        for (int i = 0; i < NREQ; i++) begin
            if (!(bus.req_valid[i] && last_hs != i)) begin
                bus.req_valid[i] = 1'($urandom_range(0, 1));
                bus.req_reg[i]   = 5'($urandom_range(0, 31));
            end
        end
    endtask

    task automatic idle_steps(input int n);
        bus.req_valid = '0;
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int exp_g [5];
        for (int r = 0; r < 32; r++) rf[r] = 64'(r);
        rf[31] = 64'd0;
        now = 0;
        reset_model();

        rst_n         = 1'b0;
        bus.req_valid = '1;
        bus.req_reg   = '0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_req_ready", 64'(bus.req_ready), 64'd0);
        chk("reset_read_reg", 64'(bus.read_reg), 64'd31);
        chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("reset_rsp_data", bus.rsp_data, 64'd0);
        chk("reset_rsp_reg", 64'(bus.rsp_reg), 64'd0);
        chk("reset_rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("reset_a_valid", 64'(dut.a_valid), 64'd0);
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single request from requester 2 for x5.
        set_req(2, 1'b1, 5'd5);
        step();
        set_req(2, 1'b0, 5'd0);
        chk("single_read_reg", 64'(bus.read_reg), 64'd5);
        step();
        chk("single_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("single_rsp_id", 64'(bus.rsp_id), 64'd2);
        chk("single_rsp_reg", 64'(bus.rsp_reg), 64'd5);
        chk("single_rsp_data", bus.rsp_data, 64'h5);
        step();

        // x31 reads as zero through the mux; x0 returns its mux value.
        set_req(1, 1'b1, 5'd31);
        step();
        set_req(1, 1'b0, 5'd0);
        set_req(3, 1'b1, 5'd0);
        step();
        set_req(3, 1'b0, 5'd0);
        chk("x31_rsp_data", bus.rsp_data, 64'd0);
        step();
        chk("x0_rsp_data", bus.rsp_data, 64'd0);
        chk("x0_rsp_reg", 64'(bus.rsp_reg), 64'd0);
        step();

        // Back-pressure: five stalled cycles admit two reads, then drain.
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(i + 8));
        obs_g.delete();
        for (int k = 0; k < 5; k++) step();
        chk("bp_handshakes", 64'(obs_g.size()), 64'd2);
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        idle_steps(4);

        // Reset with both stages full drops both entries.
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(i + 16));
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("midrst_a_valid", 64'(dut.a_valid), 64'd0);
        chk("midrst_read_reg", 64'(bus.read_reg), 64'd31);
        chk("midrst_req_ready", 64'(bus.req_ready), 64'd0);
        reset_model();
        @(negedge clk);
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        rst_n         = 1'b1;
        obs_r.delete();
        idle_steps(3);
        chk("midrst_no_stale", 64'(obs_r.size()), 64'd0);

        // All requesters valid with the consumer always ready.
        obs_g.delete();
        obs_r.delete();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(i + 1));
        for (int k = 0; k < 5; k++) step();
        idle_steps(3);
`ifdef RF_ARB_ROUND_ROBIN_EN
        exp_g = '{0, 1, 2, 3, 0};
`else
        exp_g = '{0, 0, 0, 0, 0};
`endif
        chk("rr_grant_count", 64'(obs_g.size()), 64'd5);
        chk("rr_rsp_count", 64'(obs_r.size()), 64'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < obs_g.size()) chk("rr_grant_order", 64'(obs_g[k]), 64'(exp_g[k]));
            if (k < obs_r.size()) chk("rr_rsp_order", 64'(obs_r[k]), 64'(exp_g[k]));
        end

        // Random requests, consumer alternating ready.
        for (int r = 0; r < 31; r++) rf[r] = {$urandom(), $urandom()};
        for (int k = 0; k < 1000; k++) begin
            bus.rsp_ready = (k % 2 == 0);
            rand_req();
            step();
        end
        bus.rsp_ready = 1'b1;
        idle_steps(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
